// File: rtl/fifo_axis_drain.sv
// fifo_axis_drain: show-ahead FIFO to AXI4-Stream master adapter
// with a registered 2-entry head/skid buffer and packet framing.
module fifo_axis_drain #(
    parameter int W         = 8,
    parameter int PKT_BEATS = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         fifo_rd_empty,
    input  logic [W-1:0] fifo_rd_data,
    output logic         fifo_rd_en,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic [W-1:0] m_tdata,
    output logic         m_tlast,
    input  logic         enable,
    input  logic         flush,
    output logic         pkt_done,
    output logic [15:0]  pkt_count
);

    localparam int BW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_BEATS - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e          state_q, state_d;
    logic [W:0]    head_q, head_d;
    logic [W:0]    skid_q, skid_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          done_q, done_d;
    logic [15:0]   cnt_q, cnt_d;

    logic          pop;
    logic          xfer;
    logic [W:0]    word;

    // Pop decision uses only registered occupancy, never m_tready.
    assign pop  = ~fifo_rd_empty & enable & ~flush & ~reset
                & (state_q != TWO);
    assign xfer = m_tvalid & m_tready;
    assign word = {(beat_q == LAST_BEAT), fifo_rd_data};

    assign fifo_rd_en = pop;
    assign m_tvalid   = (state_q != EMPTY);
    assign m_tdata    = head_q[W-1:0];
    assign m_tlast    = head_q[W];
    assign pkt_done   = done_q;
    assign pkt_count  = cnt_q;

    // Occupancy, buffer routing and beat framing next state.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        beat_d  = beat_q;
        if (flush) begin
            state_d = EMPTY;
            beat_d  = '0;
        end else begin
            if (pop) begin
                beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
            end
            unique case (state_q)
                EMPTY: begin
                    if (pop) begin
                        state_d = ONE;
                        head_d  = word;
                    end
                end
                ONE: begin
                    if (pop && xfer) begin
                        head_d = word;
                    end else if (pop) begin
                        state_d = TWO;
                        skid_d  = word;
                    end else if (xfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (xfer) begin
                        state_d = ONE;
                        head_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Delivered-packet pulse and counter; a beat taken during a
    // flush cycle still counts because downstream accepted it.
    always_comb begin
        done_d = xfer & m_tlast;
        cnt_d  = cnt_q + {15'd0, done_d};
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_axis_drain.sv
// tb_fifo_axis_drain: scoreboard bench for fifo_axis_drain
// with directed streaming, stall, flush, enable and wrap cases.
module tb_fifo_axis_drain;

    logic        clk;
    logic        reset;
    logic        f_empty;
    logic [7:0]  f_data;
    logic        f_rd;
    logic        tvalid;
    logic        tready;
    logic [7:0]  tdata;
    logic        tlast;
    logic        en;
    logic        flush;
    logic        done;
    logic [15:0] cnt;

    logic        e1;
    logic [7:0]  data1;
    logic        d1_rd;
    logic        d1_valid;
    logic        rdy1;
    logic [7:0]  d1_data;
    logic        d1_last;
    logic        en1;
    logic        fl1;
    logic        d1_done;
    logic [15:0] d1_cnt;

    logic [8:0]  exp_q[$];
    logic [7:0]  fifo_q[$];
    logic [8:0]  prev_beat;
    logic [8:0]  e_beat;
    bit          stall;
    bit          rnd;
    logic        gap;
    int          total;
    int          bad;
    int          pops;

    fifo_axis_drain #(.W(8), .PKT_BEATS(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_rd_empty(f_empty),
        .fifo_rd_data (f_data),
        .fifo_rd_en   (f_rd),
        .m_tvalid     (tvalid),
        .m_tready     (tready),
        .m_tdata      (tdata),
        .m_tlast      (tlast),
        .enable       (en),
        .flush        (flush),
        .pkt_done     (done),
        .pkt_count    (cnt)
    );

    fifo_axis_drain #(.W(8), .PKT_BEATS(1)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .fifo_rd_empty(e1),
        .fifo_rd_data (data1),
        .fifo_rd_en   (d1_rd),
        .m_tvalid     (d1_valid),
        .m_tready     (rdy1),
        .m_tdata      (d1_data),
        .m_tlast      (d1_last),
        .enable       (en1),
        .flush        (fl1),
        .pkt_done     (d1_done),
        .pkt_count    (d1_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic drive_fifo();
        f_empty = (fifo_q.size() == 0) || gap;
        f_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic load(input logic [7:0] d, input logic l,
                        input bit scored);
        fifo_q.push_back(d);
        if (scored) exp_q.push_back({l, d});
        drive_fifo();
    endtask

    task automatic cyc();
        logic p;
        @(negedge clk);
        p = f_rd;
        @(posedge clk);
        #1;
        if (p) begin
            void'(fifo_q.pop_front());
            pops++;
        end
        if (rnd) begin
            tready = ($urandom_range(0, 3) != 0);
            gap    = ($urandom_range(0, 4) == 0);
        end
        drive_fifo();
    endtask

    task automatic drain(input int bound, output int n);
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            cyc();
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    // Monitor: pop expected beats on each handshake, check stall rules.
    always @(negedge clk) begin
        if (!reset) begin
            if (stall) begin
                chk("stable_valid", tvalid, 1);
                chk("stable_beat", {tlast, tdata}, prev_beat);
            end
            if (f_empty) chk("rd_when_empty", f_rd, 0);
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat got=%0h want=none",
                             {tlast, tdata});
                end else begin
                    e_beat = exp_q.pop_front();
                    chk("beat", {tlast, tdata}, e_beat);
                end
            end
            stall     = tvalid && !tready && !flush;
            prev_beat = {tlast, tdata};
        end
    end

    task automatic main_tests();
        int n;
        // Streaming 0x01..0x08
        tready = 1'b1;
        for (int i = 1; i <= 8; i++) load(8'(i), (i % 4) == 0, 1);
        drain(50, n);
        chk("stream_cycles", n, 9);
        chk("stream_cnt", cnt, 2);
        chk("stream_done", done, 1);
        cyc();
        chk("done_pulse", done, 0);

        // Backpressure
        tready = 1'b0;
        for (int i = 0; i < 6; i++) load(8'(8'h11 + i), i == 3, 1);
        pops = 0;
        repeat (10) cyc();
        chk("bp_pops", pops, 2);
        chk("bp_rd_en", f_rd, 0);
        chk("bp_tdata", tdata, 8'h11);
        chk("bp_tvalid", tvalid, 1);
        tready = 1'b1;
        drain(50, n);
        chk("bp_cycles", n, 6);
        chk("bp_cnt", cnt, 3);

        // Flush with beats 3 and 0 buffered
        load(8'h22, 1'b0, 1);
        drain(50, n);
        tready = 1'b0;
        load(8'h23, 1'b1, 0);
        load(8'h24, 1'b0, 0);
        repeat (3) cyc();
        chk("pre_flush_tdata", tdata, 8'h23);
        for (int i = 0; i < 4; i++) load(8'(8'h31 + i), i == 3, 1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_valid", tvalid, 0);
        tready = 1'b1;
        drain(50, n);
        chk("flush_cycles", n, 5);
        chk("flush_cnt", cnt, 4);

        // Enable low with two buffered
        tready = 1'b0;
        for (int i = 0; i < 4; i++) load(8'(8'h41 + i), i == 3, 1);
        repeat (3) cyc();
        en = 1'b0;
        tready = 1'b1;
        pops = 0;
        repeat (6) cyc();
        chk("en_pops", pops, 0);
        chk("en_left", exp_q.size(), 2);
        chk("en_valid", tvalid, 0);
        en = 1'b1;
        drain(50, n);
        chk("en_cnt", cnt, 5);

        // Random stalls and empty gaps
        rnd = 1'b1;
        for (int i = 0; i < 1000; i++)
            load(8'($urandom_range(0, 255)), (i % 4) == 3, 1);
        drain(20000, n);
        rnd    = 1'b0;
        gap    = 1'b0;
        tready = 1'b1;
        drive_fifo();
        cyc();
        chk("rand_cnt", cnt, 255);
    endtask

    task automatic wrap_test();
        int n1;
        int guard;
        en1  = 1'b1;
        rdy1 = 1'b1;
        n1 = 0;
        guard = 0;
        while (n1 < 65536 && guard < 70000) begin
            @(negedge clk);
            guard++;
            if (n1 == 1 || n1 == 2 || n1 == 65535)
                chk("pb1_cnt", d1_cnt, 32'(n1));
            if (d1_valid && rdy1) begin
                if (n1 < 8) chk("pb1_last", d1_last, 1);
                n1++;
            end
        end
        chk("pb1_xfers", n1, 65536);
        @(posedge clk);
        #1;
        en1  = 1'b0;
        rdy1 = 1'b0;
        chk("wrap_cnt", d1_cnt, 0);
        chk("wrap_done", d1_done, 1);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        pops   = 0;
        stall  = 0;
        rnd    = 0;
        gap    = 1'b0;
        reset  = 1'b1;
        en     = 1'b1;
        tready = 1'b0;
        flush  = 1'b0;
        f_empty = 1'b0;
        f_data  = 8'h5A;
        e1    = 1'b0;
        data1 = 8'hA5;
        en1   = 1'b0;
        rdy1  = 1'b0;
        fl1   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", f_rd, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", cnt, 0);
        drive_fifo();
        reset = 1'b0;
        fork
            main_tests();
            wrap_test();
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_axis_drain.md
FIFO_AXIS_DRAIN -- requirements
Module: fifo_axis_drain

Interface
REQ-001 Parameter W, default 8, data width in bits; legal range 1..1024.
REQ-002 Parameter PKT_BEATS, default 4, beats per packet, used for tlast generation; legal range 1..65535.
REQ-003 Port clk, input, 1 bit: clock; reset reset, synchronous, active-high; clock clk.
REQ-004 Port reset, input, 1 bit: synchronous active-high reset.
REQ-005 Port fifo_rd_empty, input, 1 bit: upstream FIFO empty flag.
REQ-006 Port fifo_rd_data, input, W bits: upstream FIFO head data, show-ahead, valid whenever fifo_rd_empty is low.
REQ-007 Port fifo_rd_en, output, 1 bit: pops the upstream FIFO head.
REQ-008 Port m_tvalid, output, 1 bit: AXI4-Stream valid.
REQ-009 Port m_tready, input, 1 bit: AXI4-Stream ready.
REQ-010 Port m_tdata, output, W bits: AXI4-Stream data.
REQ-011 Port m_tlast, output, 1 bit: AXI4-Stream last.
REQ-012 Port enable, input, 1 bit: permits popping the FIFO; draining of already-buffered beats continues when low.
REQ-013 Port flush, input, 1 bit: synchronous discard of buffered beats and restart of packet framing.
REQ-014 Port pkt_done, output, 1 bit: one-cycle pulse per delivered tlast beat.
REQ-015 Port pkt_count, output, 16 bits: count of delivered packets; wraps from 0xFFFF to 0.

Function
REQ-016 The block SHALL hold a 2-entry output buffer, each entry W+1 bits (data, last), organised as head and skid registers.
REQ-017 The buffer state machine SHALL have states EMPTY, ONE and TWO, encoded in a registered occupancy.
REQ-018 The block SHALL define pop = fifo_rd_en, and xfer = m_tvalid & m_tready.
REQ-019 In EMPTY: pop goes to ONE; no pop stays in EMPTY.
REQ-020 In ONE: pop & ~xfer goes to TWO; ~pop & xfer goes to EMPTY; otherwise the state stays ONE.
REQ-021 In TWO: xfer goes to ONE, and the skid entry moves to the head; otherwise the state stays TWO.
REQ-022 fifo_rd_en SHALL equal ~fifo_rd_empty & enable & ~flush & ~reset & (state != TWO), so it never depends combinationally on m_tready.
REQ-023 fifo_rd_en SHALL never be asserted while fifo_rd_empty is high.
REQ-024 The popped fifo_rd_data SHALL be captured on the pop clock edge; a pop in EMPTY, or a pop in ONE with xfer, SHALL load the head register, and any other pop SHALL load the skid register.
REQ-025 m_tvalid SHALL be (state != EMPTY), driven only from registers; m_tdata and m_tlast SHALL come from the head entry.
REQ-026 Latency: a FIFO word popped at edge N SHALL appear on m_tdata with m_tvalid high from edge N onward, i.e. in the cycle after the pop cycle.
REQ-027 Sustained throughput SHALL be 1 beat/cycle when the FIFO is non-empty and m_tready is held high.
REQ-028 Once m_tvalid is high, m_tvalid, m_tdata and m_tlast SHALL stay stable until xfer.
REQ-029 Beats SHALL leave in exactly the FIFO pop order, with no loss or duplication.
REQ-030 A beat counter of width max(1,$clog2(PKT_BEATS)) SHALL increment on each pop.
REQ-031 The beat counter SHALL wrap to 0 after the value PKT_BEATS-1.
REQ-032 The last bit stored with a popped word SHALL be 1 exactly when the beat counter equals PKT_BEATS-1; when PKT_BEATS=1, every beat SHALL be last.
REQ-033 pkt_done SHALL be registered and pulse high in the cycle after an xfer with m_tlast=1.
REQ-034 pkt_count SHALL increment together with the pkt_done pulse.
REQ-035 flush high SHALL force, at the next edge: state to EMPTY, beat counter to 0, and pop suppressed; flush SHALL have priority over pop and xfer.
REQ-036 An xfer in a flush cycle completes as seen by downstream; pkt_done and pkt_count SHALL still update for it.
REQ-037 flush SHALL NOT clear pkt_count.
REQ-038 enable low SHALL stop pops only; buffered beats SHALL still drain, and the beat counter SHALL hold its value.

Reset
REQ-039 While reset is high at an edge: state goes to EMPTY, the beat counter to 0, the data/last registers to 0, pkt_count to 0 and pkt_done to 0.
REQ-040 Output values after reset SHALL be: m_tvalid=0, m_tdata=0, m_tlast=0, fifo_rd_en=0, pkt_done=0, pkt_count=0.
REQ-041 fifo_rd_en SHALL be 0 combinationally while reset is high.
REQ-042 Reset asserted mid-packet SHALL drop buffered beats and restart framing at beat 0.

Verification
REQ-043 Streaming: PKT_BEATS=4, FIFO holds 0x01..0x08, m_tready=1 -> 8 consecutive beats 0x01..0x08, m_tlast on 0x04 and 0x08, pkt_count ends at 2.
REQ-044 Backpressure: m_tready=0 for 10 cycles with FIFO non-empty -> exactly 2 pops then fifo_rd_en=0, m_tdata stable at the first word; m_tready then high -> order preserved and no gaps.
REQ-045 Random stall: 1000 random words, random m_tready, random FIFO empty gaps -> scoreboard matches; fifo_rd_en never high while empty; tvalid/tdata stable while stalled.
REQ-046 Flush: flush pulsed after beat 2 of a 4-beat packet with 2 words buffered -> m_tvalid=0 next cycle; next popped word tagged as beat 0, with tlast on its 4th beat.
REQ-047 Edge cases: PKT_BEATS=1 -> every beat has m_tlast=1; enable=0 with TWO buffered -> both drain, then no pops; 65536 packets -> pkt_count wraps to 0.
